// File: rtl/acc_reg_file.sv
// Dual-read, single-write register file with accumulate-on-write and a sequential clear.
// Define ACC_REG_FILE_SAT_EN to saturate overflowing accumulates; otherwise they wrap.
module acc_reg_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_acc,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  input  logic             clr_start,
  output logic             busy,
  output logic             ovf
);

  // state | meaning
  // IDLE  | normal read/write/accumulate traffic accepted
  // CLEAR | zeroing one entry per cycle at clr_idx; all requests ignored
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    clr_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             idle, clr_go, wr_go, rd_go, acc_ovf;
  logic             wr_in_range, a_in_range, b_in_range;
  logic [WIDTH-1:0] cur, new_val, rd_val_a, rd_val_b;
  logic [WIDTH:0]   sum;

  always_comb begin
    idle        = (state == IDLE);
    wr_in_range = {1'b0, wr_addr}   < (AW+1)'(DEPTH);
    a_in_range  = {1'b0, rd_addr_a} < (AW+1)'(DEPTH);
    b_in_range  = {1'b0, rd_addr_b} < (AW+1)'(DEPTH);
    clr_go      = idle && clr_start;
    wr_go       = idle && !clr_start && wr_en && wr_in_range;
    rd_go       = idle && rd_en;

    cur     = wr_in_range ? mem[wr_addr] : '0;
    sum     = {1'b0, cur} + {1'b0, wr_data};
    acc_ovf = wr_acc && sum[WIDTH];
    if (!wr_acc) begin
      new_val = wr_data;
    end else if (sum[WIDTH]) begin
`ifdef ACC_REG_FILE_SAT_EN
      new_val = '1;
`else
      new_val = sum[WIDTH-1:0];
`endif
    end else begin
      new_val = sum[WIDTH-1:0];
    end

    // write-first bypass so a same-cycle read sees the post-write value
    rd_val_a = '0;
    if (a_in_range) rd_val_a = (wr_go && rd_addr_a == wr_addr) ? new_val : mem[rd_addr_a];
    rd_val_b = '0;
    if (b_in_range) rd_val_b = (wr_go && rd_addr_b == wr_addr) ? new_val : mem[rd_addr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clr_idx   <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_go) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
            ovf     <= 1'b0;
          end else if (wr_go) begin
            mem[wr_addr] <= new_val;
            if (acc_ovf) ovf <= 1'b1;
          end
          if (rd_go) begin
            rd_data_a <= rd_val_a;
            rd_data_b <= rd_val_b;
            rd_valid  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[clr_idx] <= '0;
          if (clr_idx == AW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_reg_file.sv
// Scoreboard bench for acc_reg_file: stimulus pushes expected read pairs, a monitor pops on rd_valid.
module tb_acc_reg_file;

  logic       clk = 1'b0;
  logic       reset, wr_en, wr_acc, rd_en, clr_start;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  logic       rd_valid, busy, ovf;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  acc_reg_file #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid),
    .clr_start(clr_start), .busy(busy), .ovf(ovf)
  );

  // monitor: every rd_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got a=%02h b=%02h required no rd_valid", rd_data_a, rd_data_b);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({rd_data_a, rd_data_b} !== e) begin
          failures++;
          $display("FAIL rd_data got a=%02h b=%02h required a=%02h b=%02h",
                   rd_data_a, rd_data_b, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%02h required=%02h", name, got, req);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic acc);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_acc = acc;
    tick();
    wr_en = 1'b0; wr_acc = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b, input logic [7:0] ea, input logic [7:0] eb);
    rd_en = 1'b1; rd_addr_a = a; rd_addr_b = b;
    exp_q.push_back({ea, eb});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] d);
    for (int i = 0; i < 8; i++) wr(3'(i), d, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_en = 0; wr_acc = 0; rd_en = 0; clr_start = 0;
    wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_ovf", {7'd0, ovf}, 8'h00);
    check("reset_valid", {7'd0, rd_valid}, 8'h00);
    check("reset_rd_a", rd_data_a, 8'h00);

    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i), 8'h00, 8'h00);

    wr(3, 8'h12, 1'b0);
    wr(3, 8'h05, 1'b1);
    rd(3, 0, 8'h17, 8'h00);
    check("acc_no_ovf", {7'd0, ovf}, 8'h00);

    // accumulate with same-cycle read of the target: write-first returns the sum
    wr_en = 1; wr_acc = 1; wr_addr = 3; wr_data = 8'h01;
    rd(3, 3, 8'h18, 8'h18);
    wr_en = 0; wr_acc = 0;
    tick();
    check("rd_hold_a", rd_data_a, 8'h18);
    check("rd_hold_valid", {7'd0, rd_valid}, 8'h00);

    wr(1, 8'hF0, 1'b0);
    wr(1, 8'h20, 1'b1);
`ifdef ACC_REG_FILE_SAT_EN
    rd(1, 3, 8'hFF, 8'h18);
`else
    rd(1, 3, 8'h10, 8'h18);
`endif
    check("acc_ovf_set", {7'd0, ovf}, 8'h01);

    wr_en = 1; wr_addr = 2; wr_data = 8'h44;
    rd(2, 2, 8'h44, 8'h44);
    wr_en = 0;

    // clear with a coincident write (dropped) and traffic during busy (ignored)
    fill(8'hAA);
    clr_start = 1; wr_en = 1; wr_addr = 0; wr_data = 8'h55; rd_en = 1;
    exp_q.push_back({8'hAA, 8'hAA});
    tick();
    clr_start = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      else begin rd_en = 0; wr_en = 0; end
      tick();
    end
    rd_en = 0; wr_en = 0;
    check("clr_busy_cycles", 8'(n), 8'd8);
    check("clr_ovf", {7'd0, ovf}, 8'h00);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i), 8'h00, 8'h00);

    // reset mid-clear at index 4
    fill(8'hAA);
    wr(5, 8'hF0, 1'b1);
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (4) tick();
    check("midclr_busy_before", {7'd0, busy}, 8'h01);
    reset = 1;
    tick();
    reset = 0;
    check("midclr_busy", {7'd0, busy}, 8'h00);
    check("midclr_ovf", {7'd0, ovf}, 8'h00);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i), 8'h00, 8'h00);
    wr(6, 8'h3C, 1'b0);
    rd(6, 6, 8'h3C, 8'h3C);

    tick(); tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
